// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a small circular fetch queue.
//
// The PC register addresses instruction memory combinationally; each cycle
// the returned word is pushed into the queue together with its PC whenever
// there is room (or the head is being drained in the same cycle). The queue
// head is presented to decode with a valid/ready handshake. A redirect
// flushes the queue and restarts fetch at the word-aligned target.
//
// Parameters:
//   RESET_PC  PC loaded by reset
//   QDEPTH    fetch queue depth, 2 or 4 (pointers wrap by natural overflow)
//
// Optional feature macro:
//   STATIC_BTFN_EN  static backward-taken/forward-not-taken prediction for
//                   conditional branches; undefined -> always pc+4 and
//                   out_pred_taken tied low
//
// Ports:
//   clk             clock, all state updates on rising edge
//   reset           synchronous, active-high
//   imem_addr       instruction memory byte address (= pc)
//   imem_rdata      instruction word for imem_addr, same cycle
//   redirect_valid  flush and refetch from redirect_pc
//   redirect_pc     redirect target (low two bits ignored)
//   out_valid       queue head valid toward decode
//   out_ready       decode accepts the head
//   out_pc          PC of the head instruction
//   out_instr       head instruction word
//   out_pred_taken  head was fetched under a taken prediction
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_pred_taken
);

  // Depth is restricted to powers of two so pointer increment wraps for free.
  localparam int PW = (QDEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  logic [63:0]   pc;
  logic [63:0]   pc_next;
  logic [63:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          deq;
  logic          enq;
  logic          unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_pc    = q_pc[head];
  assign out_instr = q_instr[head];

  assign deq = out_valid && out_ready;
  // A full queue that is draining this cycle still accepts the new fetch.
  assign enq = !redirect_valid && ((count < CW'(QDEPTH)) || deq);

`ifdef STATIC_BTFN_EN
  logic          q_pred [QDEPTH];
  logic          pred_taken;
  logic [63:0]   b_imm;

  assign b_imm = {{51{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                  imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  // Sign bit of the B-immediate set means a backward branch: predict taken.
  assign pred_taken = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
  assign pc_next    = pred_taken ? (pc + b_imm) : (pc + 64'd4);
  // Gate with out_valid so a stale entry left behind by a flush never shows.
  assign out_pred_taken = out_valid && q_pred[head];

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      q_pred[tail] <= pred_taken;
    end
  end
`else
  assign pc_next        = pc + 64'd4;
  assign out_pred_taken = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      // Any handshake this cycle is discarded along with the queue contents.
      pc    <= {redirect_pc[63:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        q_pc[tail]    <= pc;
        q_instr[tail] <= imem_rdata;
        tail          <= tail + 1'b1;
        pc            <= pc_next;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC loaded by reset.
REQ-002 SHALL have parameter QDEPTH, default 2, the fetch queue depth; legal values are 2 or 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous and active-high.
REQ-005 SHALL have port imem_addr, output, 64, the instruction memory byte address.
REQ-006 SHALL have port imem_rdata, input, 32, the instruction word, combinational from imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1, a branch or jump resolved later in the pipe; flush and refetch.
REQ-008 SHALL have port redirect_pc, input, 64, the redirect target.
REQ-009 SHALL have port out_valid, output, 1, the queue head is valid toward decode.
REQ-010 SHALL have port out_ready, input, 1, decode accepts the head (stall when low).
REQ-011 SHALL have port out_pc, output, 64, the PC of the head instruction.
REQ-012 SHALL have port out_instr, output, 32, the head instruction word.
REQ-013 SHALL have port out_pred_taken, output, 1, the head was fetched under a taken prediction; 0 when STATIC_BTFN_EN is undefined.

Function
REQ-014 SHALL drive imem_addr = pc combinationally.
REQ-015 SHALL hold 0..QDEPTH entries of {pc, instr, pred} in a circular queue with head/tail pointers that wrap modulo QDEPTH, plus a count register.
REQ-016 SHALL assert out_valid iff count != 0, with out_pc, out_instr and out_pred_taken taken from the head entry.
REQ-017 SHALL dequeue (deq) when out_valid && out_ready; out_* SHALL be held stable while out_valid && !out_ready.
REQ-018 SHALL enqueue (enq) {pc, imem_rdata} when !redirect_valid && (count < QDEPTH || deq); a full queue with a simultaneous deq SHALL still fetch.
REQ-019 SHALL advance pc on enq to pc+4 (modulo 2^64, 64'hFFFF_FFFF_FFFF_FFFC wraps to 0), or to the predicted target per REQ-025; without enq, pc SHALL hold.
REQ-020 SHALL, on redirect_valid, set count=0, reset both pointers and load pc <= {redirect_pc[63:2], 2'b00}; it SHALL perform no enq that cycle and SHALL ignore any deq that cycle.
REQ-021 SHALL produce latency: redirect asserted in cycle N -> out_valid=0 in N+1 -> out_valid=1 with out_pc=target in N+2 (given no further redirect).
REQ-022 SHALL keep the count update consistent: enq&&deq leaves count unchanged; count SHALL never exceed QDEPTH or underflow.

Reset
REQ-023 SHALL, while reset=1, force pc=RESET_PC, count=0, pointers=0, out_valid=0, out_pred_taken=0; reset SHALL override redirect_valid and any enq/deq.
REQ-024 SHALL, with reset released before edge K, present out_valid=1, out_pc=RESET_PC in the cycle after edge K; reset asserted mid-stream SHALL discard all queued entries.

Configuration
REQ-025 SHALL, with macro STATIC_BTFN_EN defined, decode imem_rdata opcode 7'b1100011 with B-immediate sign bit 1 (backward) as predicted taken: next pc = pc + sext(B-imm), entry pred=1; all other instructions pred=0, pc+4.
REQ-026 SHALL, without STATIC_BTFN_EN, always use pc+4, tie out_pred_taken=0, and omit the decode logic.

Verification
REQ-027 SHALL check reset: RESET_PC=0x1000, reset released, out_ready=1 -> out_pc sequence 0x1000, 0x1004, 0x1008 on consecutive cycles.
REQ-028 SHALL check stall: out_ready=0 for 5 cycles -> count saturates at QDEPTH, out_pc held at 0x1000, imem_addr held at 0x1000+4*QDEPTH; release -> no PC skipped or duplicated.
REQ-029 SHALL check redirect: redirect_pc=0x2003 in cycle N with a full queue -> out_valid=0 at N+1, out_pc=0x2000 at N+2.
REQ-030 SHALL check redirect while out_ready=1 and the head is valid: the head is dropped, not consumed, and the next valid out_pc is the target.
REQ-031 SHALL check wrap: redirect to 0xFFFF_FFFF_FFFF_FFF8 -> out_pc 0x...FFF8, 0x...FFFC, 0x0.
REQ-032 SHALL check STATIC_BTFN_EN: at 0x100, BEQ imm=-8 -> out_pred_taken=1 and next out_pc=0xF8; BEQ imm=+8 -> out_pred_taken=0 and next out_pc=0x104.
